// File: rtl/hazard_stall_ctrl.sv
// Purpose : stall/flush generator for a 5-stage RV32I pipeline. It tracks in-flight
//           destinations in an E/M/W scoreboard and resolves load-use, branch and
//           data-memory-wait hazards.
// Latency : stall and flush outputs are combinational from FSM state, scoreboard and
//           D-stage inputs. Scoreboard, FSM and counters update on the next rising edge.
// Backpressure: while the load/store in M waits (mem_ready=0), the whole pipeline freezes.
// Ports   : clk/rst (synchronous, active-high); D-stage Rs1_D/Rs2_D/UseRs1D/UseRs2D/
//           RD_D/RegWriteD/LoadD/MemD; PCSrcE (taken branch in E); mem_ready (M access done);
//           StallF/D/E/M, FlushD/E; mem_timeout (sticky); stall_cnt (STALL_PERF_CNT_EN only).
// Config  : define STALL_PERF_CNT_EN to add the stall_cnt performance counter.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64
`ifdef STALL_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic       UseRs1D,
    input  logic       UseRs2D,
    input  logic [4:0] RD_D,
    input  logic       RegWriteD,
    input  logic       LoadD,
    input  logic       MemD,
    input  logic       PCSrcE,
    input  logic       mem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       mem_timeout
`ifdef STALL_PERF_CNT_EN
    , output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       load;
        logic       mem;
    } sb_ent_t;

    state_t             state_q;
    sb_ent_t            e_q, m_q, w_q;
    sb_ent_t            e_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               mem_timeout_q;
    logic               freeze;
    logic               lu_hit;

    // The W entry and parts of M are kept for pipeline bookkeeping only.
    logic sb_unused;
    assign sb_unused = ^{w_q, m_q.rd, m_q.load};

    // A load/store sitting in M without mem_ready freezes the whole pipe.
    assign freeze = m_q.vld && m_q.mem && !mem_ready;

    // Load-use hit. In LU_STALL a bubble occupies E, so a hit is impossible there.
    assign lu_hit = (state_q != LU_STALL) && e_q.vld && e_q.load && (e_q.rd != 5'd0) &&
                    ((UseRs1D && (e_q.rd == Rs1_D)) || (UseRs2D && (e_q.rd == Rs2_D)));

    // Priority: freeze > branch flush > load-use stall.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            // All outputs stay low during reset.
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lu_hit) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // The D->E entry becomes a bubble whenever E is flushed or D is held.
    always_comb begin
        e_d      = '0;
        e_d.vld  = RegWriteD | MemD;
        e_d.rd   = RD_D;
        e_d.load = LoadD;
        e_d.mem  = MemD;
        if (FlushE || StallD) begin
            e_d = '0;
        end
    end

    // The counter runs only on freeze cycles and saturates at MEM_TIMEOUT.
    always_comb begin
        tmo_cnt_d = '0;
        if (freeze) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_W'(MEM_TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            e_q           <= '0;
            m_q           <= '0;
            w_q           <= '0;
            tmo_cnt_q     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            if (!freeze) begin
                e_q <= e_d;
                m_q <= e_q;
                w_q <= m_q;
            end
            // A taken branch kills the D instruction, so no load-use stall follows it.
            if (freeze) begin
                state_q <= MEM_WAIT;
            end else if (lu_hit && !PCSrcE) begin
                state_q <= LU_STALL;
            end else begin
                state_q <= RUN;
            end
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_cnt_q == TMO_W'(MEM_TIMEOUT)) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign mem_timeout = mem_timeout_q && !rst;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = rst ? '0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl. Each scenario builds a per-cycle stimulus
// sequence with expected outputs, then pushes and pops expectations through a queue.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, RD_D;
    logic       UseRs1D, UseRs2D, RegWriteD, LoadD, MemD, PCSrcE, mem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .RD_D(RD_D), .RegWriteD(RegWriteD), .LoadD(LoadD), .MemD(MemD),
        .PCSrcE(PCSrcE), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout)
`ifdef STALL_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // exp = {mem_timeout, StallF, StallD, StallE, StallM, FlushD, FlushE}
    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       br;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       mm;
        logic [6:0] exp;
        logic       tdc;   // mem_timeout not checked this cycle
    } stim_t;

    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_LU   = 6'b110001;
    localparam logic [5:0] O_BR   = 6'b000011;
    localparam logic [5:0] O_FRZ  = 6'b111100;

    int    n_cmp = 0;
    int    n_err = 0;
    stim_t exp_q[$];
    stim_t e;
    logic [6:0] got, mask;
`ifdef STALL_PERF_CNT_EN
    int    exp_cnt = 0;
    stim_t prev;
`endif

    function automatic stim_t mk(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                 logic [4:0] rd, logic rw, logic ld, logic mm, logic [5:0] o);
        stim_t s;
        s     = '0;
        s.mr  = 1'b1;
        s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        s.rd  = rd;  s.rw = rw; s.ld  = ld;  s.mm = mm;
        s.exp = {1'b0, o};
        return s;
    endfunction

    function automatic stim_t f_idle(logic [5:0] o);
        return mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, o);
    endfunction

    function automatic stim_t f_lw(logic [4:0] rd, logic [5:0] o);
        return mk(5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b1, o);
    endfunction

    function automatic stim_t f_sw(logic [5:0] o);
        return mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, o);
    endfunction

    function automatic stim_t f_use(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                    logic [5:0] o);
        return mk(rs1, u1, rs2, u2, 5'd10, 1'b1, 1'b0, 1'b0, o);
    endfunction

    task automatic apply(input stim_t s);
`ifdef STALL_PERF_CNT_EN
        // Model of the perf counter, advanced by the cycle that just ended.
        if (prev.rst) exp_cnt = 0;
        else if (prev.exp[5] && exp_cnt < 65535) exp_cnt = exp_cnt + 1;
        prev = s;
`endif
        rst = s.rst; mem_ready = s.mr; PCSrcE = s.br;
        Rs1_D = s.rs1; UseRs1D = s.u1; Rs2_D = s.rs2; UseRs2D = s.u2;
        RD_D = s.rd; RegWriteD = s.rw; LoadD = s.ld; MemD = s.mm;
    endtask

    task automatic test_reset();
        stim_t seq[$];
        stim_t s;
        s = f_idle(O_NONE); s.rst = 1'b1;
        seq.push_back(s);
        seq.push_back(s);
        seq.push_back(f_idle(O_NONE));
        seq.push_back(f_idle(O_NONE));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e    = exp_q.pop_front();
            got  = {mem_timeout, StallF, StallD, StallE, StallM, FlushD, FlushE};
            mask = e.tdc ? 7'h3F : 7'h7F;
            n_cmp++;
            if ((got & mask) !== (e.exp & mask)) begin
                n_err++;
                $display("FAIL reset[%0d] got=%b expected=%b", i, got, e.exp);
            end
`ifdef STALL_PERF_CNT_EN
            n_cmp++;
            if (stall_cnt !== 16'(exp_cnt)) begin
                n_err++;
                $display("FAIL reset_stall_cnt[%0d] got=%0d expected=%0d", i, stall_cnt, exp_cnt);
            end
`endif
        end
    endtask

    task automatic test_load_use();
        stim_t seq[$];
        stim_t s;
        // lw x5 then a reader of x5 via rs1
        seq.push_back(f_lw(5'd5, O_NONE));
        seq.push_back(f_use(5'd5, 1'b1, 5'd0, 1'b0, O_LU));
        seq.push_back(f_use(5'd5, 1'b1, 5'd0, 1'b0, O_NONE));
        seq.push_back(f_idle(O_NONE));
        // lw x7 then a reader of x7 via rs2
        seq.push_back(f_lw(5'd7, O_NONE));
        seq.push_back(f_use(5'd3, 1'b1, 5'd7, 1'b1, O_LU));
        seq.push_back(f_use(5'd3, 1'b1, 5'd7, 1'b1, O_NONE));
        // a matching rs2 that is not read causes no stall
        seq.push_back(f_lw(5'd7, O_NONE));
        seq.push_back(f_use(5'd3, 1'b1, 5'd7, 1'b0, O_NONE));
        // lw x0 and a reader of x0 causes no stall
        seq.push_back(f_lw(5'd0, O_NONE));
        seq.push_back(f_use(5'd0, 1'b1, 5'd0, 1'b1, O_NONE));
        // a branch overrides load-use
        seq.push_back(f_lw(5'd5, O_NONE));
        s = f_use(5'd5, 1'b1, 5'd0, 1'b0, O_BR); s.br = 1'b1;
        seq.push_back(s);
        seq.push_back(f_use(5'd5, 1'b1, 5'd0, 1'b0, O_NONE));
        seq.push_back(f_idle(O_NONE));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e    = exp_q.pop_front();
            got  = {mem_timeout, StallF, StallD, StallE, StallM, FlushD, FlushE};
            mask = e.tdc ? 7'h3F : 7'h7F;
            n_cmp++;
            if ((got & mask) !== (e.exp & mask)) begin
                n_err++;
                $display("FAIL load_use[%0d] got=%b expected=%b", i, got, e.exp);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t seq[$];
        stim_t s;
        seq.push_back(f_sw(O_NONE));
        seq.push_back(f_lw(5'd9, O_NONE));
        // sw in M, lw x9 in E, reader of x9 in D: freeze wins, PCSrcE ignored
        for (int k = 0; k < 3; k++) begin
            s = f_use(5'd9, 1'b1, 5'd0, 1'b0, O_FRZ); s.mr = 1'b0; s.br = (k == 1);
            seq.push_back(s);
        end
        // release: the held scoreboard still shows lw x9 in E
        seq.push_back(f_use(5'd9, 1'b1, 5'd0, 1'b0, O_LU));
        seq.push_back(f_use(5'd9, 1'b1, 5'd0, 1'b0, O_NONE));
        seq.push_back(f_idle(O_NONE));
        seq.push_back(f_idle(O_NONE));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e    = exp_q.pop_front();
            got  = {mem_timeout, StallF, StallD, StallE, StallM, FlushD, FlushE};
            mask = e.tdc ? 7'h3F : 7'h7F;
            n_cmp++;
            if ((got & mask) !== (e.exp & mask)) begin
                n_err++;
                $display("FAIL mem_wait[%0d] got=%b expected=%b", i, got, e.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t seq[$];
        seq.push_back(f_lw(5'd5, O_NONE));
        seq.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, O_LU));
        seq.push_back(mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, O_NONE));
        seq.push_back(f_use(5'd6, 1'b1, 5'd5, 1'b1, O_LU));
        seq.push_back(f_use(5'd6, 1'b1, 5'd5, 1'b1, O_NONE));
        seq.push_back(f_idle(O_NONE));
        seq.push_back(f_idle(O_NONE));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e    = exp_q.pop_front();
            got  = {mem_timeout, StallF, StallD, StallE, StallM, FlushD, FlushE};
            mask = e.tdc ? 7'h3F : 7'h7F;
            n_cmp++;
            if ((got & mask) !== (e.exp & mask)) begin
                n_err++;
                $display("FAIL back_to_back[%0d] got=%b expected=%b", i, got, e.exp);
            end
`ifdef STALL_PERF_CNT_EN
            n_cmp++;
            if (stall_cnt !== 16'(exp_cnt)) begin
                n_err++;
                $display("FAIL b2b_stall_cnt[%0d] got=%0d expected=%0d", i, stall_cnt, exp_cnt);
            end
`endif
        end
    endtask

    task automatic test_mem_timeout();
        stim_t seq[$];
        stim_t s;
        seq.push_back(f_sw(O_NONE));
        seq.push_back(f_idle(O_NONE));
        for (int k = 1; k <= 66; k++) begin
            s = f_idle(O_FRZ); s.mr = 1'b0;
            s.exp[6] = (k >= 66);
            s.tdc    = (k == 65);
            seq.push_back(s);
        end
        for (int k = 0; k < 3; k++) begin
            s = f_idle(O_NONE); s.exp[6] = 1'b1;
            seq.push_back(s);
        end
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e    = exp_q.pop_front();
            got  = {mem_timeout, StallF, StallD, StallE, StallM, FlushD, FlushE};
            mask = e.tdc ? 7'h3F : 7'h7F;
            n_cmp++;
            if ((got & mask) !== (e.exp & mask)) begin
                n_err++;
                $display("FAIL mem_timeout[%0d] got=%b expected=%b", i, got, e.exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        stim_t seq[$];
        stim_t s;
        s = f_sw(O_NONE); s.exp[6] = 1'b1;
        seq.push_back(s);
        s = f_idle(O_NONE); s.exp[6] = 1'b1;
        seq.push_back(s);
        for (int k = 0; k < 2; k++) begin
            s = f_idle(O_FRZ); s.mr = 1'b0; s.exp[6] = 1'b1;
            seq.push_back(s);
        end
        // reset while frozen: outputs drop immediately
        s = f_idle(O_NONE); s.mr = 1'b0; s.rst = 1'b1;
        seq.push_back(s);
        // after reset: no residual stall even though mem_ready is still low
        s = f_idle(O_NONE); s.mr = 1'b0;
        seq.push_back(s);
        seq.push_back(f_idle(O_NONE));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e    = exp_q.pop_front();
            got  = {mem_timeout, StallF, StallD, StallE, StallM, FlushD, FlushE};
            mask = e.tdc ? 7'h3F : 7'h7F;
            n_cmp++;
            if ((got & mask) !== (e.exp & mask)) begin
                n_err++;
                $display("FAIL mid_reset[%0d] got=%b expected=%b", i, got, e.exp);
            end
`ifdef STALL_PERF_CNT_EN
            n_cmp++;
            if (stall_cnt !== (e.rst ? 16'd0 : 16'(exp_cnt))) begin
                n_err++;
                $display("FAIL mid_reset_stall_cnt[%0d] got=%0d expected=%0d", i, stall_cnt,
                         e.rst ? 0 : exp_cnt);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; PCSrcE = 1'b0;
        Rs1_D = '0; Rs2_D = '0; UseRs1D = 1'b0; UseRs2D = 1'b0;
        RD_D = '0; RegWriteD = 1'b0; LoadD = 1'b0; MemD = 1'b0;
`ifdef STALL_PERF_CNT_EN
        prev = f_idle(O_NONE);
        prev.rst = 1'b1;
`endif
        test_reset();
        test_load_use();
        test_mem_wait();
        test_back_to_back();
        test_mem_timeout();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
